// File: rtl/serial_rx_pkg.sv
// Shared types and sizing helpers for the serial line receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_rx_if.sv
// Parallel word handshake plus error pulses from the serial receiver.
interface serial_rx_if #(
  parameter int unsigned DATA_W = 8
) ();
  import serial_rx_pkg::*;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output frame_err,
    output overrun
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/serial_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  import serial_rx_pkg::*;

  logic meta;

  // Both stages reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/serial_rx.sv
// Start/stop framed, LSB-first serial receiver with registered word output.
module serial_rx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  serial_rx_if.master rx_if
);
  import serial_rx_pkg::*;

  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam int unsigned CW = cnt_w(CLKS_PER_BIT);
  localparam int unsigned BW = cnt_w(DATA_W);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              rx_s;
  rx_state_t         state, state_d;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] shreg;
  logic              cnt_clr, shift_en, word_done, ferr_d;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and sample strobes.
  always_comb begin
    state_d   = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    ferr_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bitcnt == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            word_done = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit-period counter, data-bit counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      // Idle-type states hold the counter at zero so any entry starts clean.
      if (cnt_clr || state_d != state || state == IDLE || state == BREAK)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state != DATA)  bitcnt <= '0;
      else if (shift_en)  bitcnt <= bitcnt + 1'b1;

      if (shift_en) shreg <= {rx_s, shreg[DATA_W-1:1]};
    end
  end

  // Output word register, handshake and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_if.out_data  <= '0;
      rx_if.out_valid <= 1'b0;
      rx_if.frame_err <= 1'b0;
      rx_if.overrun   <= 1'b0;
    end else begin
      rx_if.frame_err <= ferr_d;
      rx_if.overrun   <= word_done && rx_if.out_valid && !rx_if.out_ready;
      if (word_done && (!rx_if.out_valid || rx_if.out_ready)) begin
        rx_if.out_data  <= shreg;
        rx_if.out_valid <= 1'b1;
      end else if (rx_if.out_valid && rx_if.out_ready) begin
        rx_if.out_valid <= 1'b0;
      end
    end
  end
endmodule
